// File: rtl/stack_pusher.sv
// -----------------------------------------------------------------------------
// stack_pusher
//
// Push sequencer for the 6502 core. It takes a push request from the
// control/execute logic and writes one, two or three bytes into page-one stack
// memory at descending addresses. When the frame is complete it hands back the
// updated stack pointer.
//   kind 0 : single byte (PHA/PHP)           -> push_data
//   kind 1 : return address (JSR)            -> pc[15:8], pc[7:0]
//   kind 2 : interrupt frame (BRK/IRQ/NMI)   -> pc[15:8], pc[7:0], P
//   kind 3 : reserved, answered with a one-cycle err pulse
//
// Ports
//   phi1       in   clock, all state changes on its rising edge
//   reset      in   synchronous active-high reset
//   push_req   in   start request, only looked at while idle
//   push_kind  in   frame type (see above)
//   push_data  in   byte pushed for kind 0
//   pc         in   address pushed for kinds 1 and 2, used exactly as given
//   status     in   P register pushed for kind 2
//   brk        in   kind 2 only: value of bit 4 in the pushed P
//   sp         in   current stack pointer, captured when a request is accepted
//   busy       out  high from the accept cycle through the DONE cycle
//   wr_en      out  memory write strobe, one byte per cycle
//   addr       out  write address, high byte always the stack page
//   data_out   out  write data
//   done       out  one-cycle completion pulse
//   sp_load    out  pulses with done; consumer loads sp_next
//   sp_next    out  stack pointer after the frame
//   err        out  one-cycle pulse when a reserved kind is accepted
//   wrap       out  stack-wrap flag
//
// Build option
//   STACK_WRAP_FLAG_EN : when defined, wrap pulses with done if any byte of the
//                        frame was written below the 8'h00 stack slot (the
//                        pointer passed zero). When undefined, wrap is 0.
// -----------------------------------------------------------------------------
module stack_pusher #(
    parameter int                    REG_WIDTH  = 8,
    parameter int                    ADDR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] STACK_BASE = 16'h0100
) (
    input  logic                  phi1,
    input  logic                  reset,
    input  logic                  push_req,
    input  logic [1:0]            push_kind,
    input  logic [REG_WIDTH-1:0]  push_data,
    input  logic [ADDR_WIDTH-1:0] pc,
    input  logic [REG_WIDTH-1:0]  status,
    input  logic                  brk,
    input  logic [REG_WIDTH-1:0]  sp,
    output logic                  busy,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [REG_WIDTH-1:0]  data_out,
    output logic                  done,
    output logic                  sp_load,
    output logic [REG_WIDTH-1:0]  sp_next,
    output logic                  err,
    output logic                  wrap
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PUSH0 = 3'd1,
        PUSH1 = 3'd2,
        PUSH2 = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t state_q, state_d;

    // Request fields captured at accept; the frame is built only from these.
    logic [1:0]            kind_cap;
    logic [1:0]            n_cap;
    logic [REG_WIDTH-1:0]  data_cap;
    logic [ADDR_WIDTH-1:0] pc_cap;
    logic [REG_WIDTH-1:0]  status_cap;
    logic                  brk_cap;
    logic [REG_WIDTH-1:0]  sp_cap;

    // Next values of the registered outputs.
    logic                  busy_d, wr_en_d, done_d, sp_load_d, err_d, wrap_d;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic [REG_WIDTH-1:0]  data_d, sp_next_d;

    // Operand sources for the output decode.
    logic [1:0]            kind_src, n_src, k_idx;
    logic [REG_WIDTH-1:0]  data_src, status_src, sp_src, p_byte, sp_low;
    logic [ADDR_WIDTH-1:0] pc_src;
    logic                  brk_src;

    logic accept;
    logic n_is_1, n_is_2;

    assign accept = (state_q == IDLE) && push_req && (push_kind != 2'd3);
    assign n_is_1 = (state_q == IDLE) ? (push_kind == 2'd0) : (n_cap == 2'd1);
    assign n_is_2 = (state_q == IDLE) ? (push_kind == 2'd1) : (n_cap == 2'd2);

    // State register.
    always_ff @(posedge phi1) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: walk PUSH0..PUSH(n-1), then DONE, then back to IDLE.
    // Requests are only looked at in IDLE; reserved kinds never leave IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = PUSH0;
            PUSH0:   state_d = (n_cap == 2'd1) ? DONE : PUSH1;
            PUSH1:   state_d = (n_cap == 2'd2) ? DONE : PUSH2;
            PUSH2:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode. Outputs are registered from the *next* state so that the
    // first write appears in the cycle right after the accept edge. On the
    // accept edge itself the capture registers are not loaded yet, so the
    // request inputs are used directly while in IDLE.
    always_comb begin
        kind_src   = (state_q == IDLE) ? push_kind : kind_cap;
        data_src   = (state_q == IDLE) ? push_data : data_cap;
        pc_src     = (state_q == IDLE) ? pc        : pc_cap;
        status_src = (state_q == IDLE) ? status    : status_cap;
        brk_src    = (state_q == IDLE) ? brk       : brk_cap;
        sp_src     = (state_q == IDLE) ? sp        : sp_cap;

        case (kind_src)
            2'd0:    n_src = 2'd1;
            2'd1:    n_src = 2'd2;
            default: n_src = 2'd3;
        endcase

        // Pushed P always has bit 5 set; bit 4 reflects BRK versus IRQ/NMI.
        p_byte    = status_src;
        p_byte[5] = 1'b1;
        p_byte[4] = brk_src;

        busy_d    = (state_d != IDLE);
        wr_en_d   = 1'b0;
        done_d    = 1'b0;
        sp_load_d = 1'b0;
        wrap_d    = 1'b0;
        err_d     = (state_q == IDLE) && push_req && (push_kind == 2'd3);
        addr_d    = addr;
        data_d    = data_out;
        sp_next_d = sp_next;
        k_idx     = 2'd0;

        case (state_d)
            PUSH0: begin wr_en_d = 1'b1; k_idx = 2'd0; end
            PUSH1: begin wr_en_d = 1'b1; k_idx = 2'd1; end
            PUSH2: begin wr_en_d = 1'b1; k_idx = 2'd2; end
            DONE: begin
                done_d    = 1'b1;
                sp_load_d = 1'b1;
                sp_next_d = sp_src - REG_WIDTH'(n_src);
                // A write went below slot 00 exactly when sp_cap < n-1.
                wrap_d    = (sp_src < REG_WIDTH'(n_src - 2'd1));
            end
            default: ;
        endcase

        sp_low = sp_src - REG_WIDTH'(k_idx);

        if (wr_en_d) begin
            addr_d = {STACK_BASE[ADDR_WIDTH-1:REG_WIDTH], sp_low};
            case (k_idx)
                2'd0:    data_d = (kind_src == 2'd0) ? data_src
                                                     : pc_src[2*REG_WIDTH-1 -: REG_WIDTH];
                2'd1:    data_d = pc_src[REG_WIDTH-1:0];
                default: data_d = p_byte;
            endcase
        end
    end

    // Capture registers, loaded only when a request is accepted.
    always_ff @(posedge phi1) begin
        if (reset) begin
            kind_cap   <= 2'd0;
            n_cap      <= 2'd0;
            data_cap   <= '0;
            pc_cap     <= '0;
            status_cap <= '0;
            brk_cap    <= 1'b0;
            sp_cap     <= '0;
        end else if (accept) begin
            kind_cap   <= push_kind;
            n_cap      <= n_is_1 ? 2'd1 : (n_is_2 ? 2'd2 : 2'd3);
            data_cap   <= push_data;
            pc_cap     <= pc;
            status_cap <= status;
            brk_cap    <= brk;
            sp_cap     <= sp;
        end
    end

    // Output registers. Reset clears everything, which also abandons any
    // partial frame without a done/sp_load.
    always_ff @(posedge phi1) begin
        if (reset) begin
            busy     <= 1'b0;
            wr_en    <= 1'b0;
            addr     <= '0;
            data_out <= '0;
            done     <= 1'b0;
            sp_load  <= 1'b0;
            sp_next  <= '0;
            err      <= 1'b0;
        end else begin
            busy     <= busy_d;
            wr_en    <= wr_en_d;
            addr     <= addr_d;
            data_out <= data_d;
            done     <= done_d;
            sp_load  <= sp_load_d;
            sp_next  <= sp_next_d;
            err      <= err_d;
        end
    end

`ifdef STACK_WRAP_FLAG_EN
    // Wrap flag register, pulsed together with done.
    always_ff @(posedge phi1) begin
        if (reset) begin
            wrap <= 1'b0;
        end else begin
            wrap <= wrap_d;
        end
    end
`else
    assign wrap = 1'b0;
    logic unused_wrap;
    assign unused_wrap = wrap_d;
`endif

endmodule

// File: tb/tb_stack_pusher.sv
// -----------------------------------------------------------------------------
// tb_stack_pusher
//
// Directed bench for stack_pusher. Inputs are driven 1 ns after each rising
// edge and outputs are sampled at the same point, well away from the next edge.
// -----------------------------------------------------------------------------
module tb_stack_pusher;

    logic        phi1 = 1'b0;
    logic        reset;
    logic        push_req;
    logic [1:0]  push_kind;
    logic [7:0]  push_data;
    logic [15:0] pc;
    logic [7:0]  status;
    logic        brk;
    logic [7:0]  sp;
    logic        busy, wr_en, done, sp_load, err, wrap;
    logic [15:0] addr;
    logic [7:0]  data_out, sp_next;

    int compared   = 0;
    int mismatched = 0;
    logic exp_wrap;

    stack_pusher dut (
        .phi1      (phi1),
        .reset     (reset),
        .push_req  (push_req),
        .push_kind (push_kind),
        .push_data (push_data),
        .pc        (pc),
        .status    (status),
        .brk       (brk),
        .sp        (sp),
        .busy      (busy),
        .wr_en     (wr_en),
        .addr      (addr),
        .data_out  (data_out),
        .done      (done),
        .sp_load   (sp_load),
        .sp_next   (sp_next),
        .err       (err),
        .wrap      (wrap)
    );

    always #5 phi1 = ~phi1;

    // Advance one clock and settle just past the edge.
    task automatic step();
        @(posedge phi1);
        #1;
    endtask

    // Drive a full set of request inputs.
    task automatic applyStimulus(input logic req, input logic [1:0] kind,
                                 input logic [7:0] d, input logic [15:0] p,
                                 input logic [7:0] st, input logic b,
                                 input logic [7:0] s);
        push_req  = req;
        push_kind = kind;
        push_data = d;
        pc        = p;
        status    = st;
        brk       = b;
        sp        = s;
    endtask

    // One comparison: count it, and report any difference.
    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // Check a write cycle: strobe, address, data, still busy, no done.
    task automatic checkWrite(input string tag, input logic [15:0] a,
                              input logic [7:0] d);
        checkOutput({tag, " wr_en"}, 32'(wr_en), 32'd1);
        checkOutput({tag, " addr"},  32'(addr),  32'(a));
        checkOutput({tag, " data"},  32'(data_out), 32'(d));
        checkOutput({tag, " busy"},  32'(busy),  32'd1);
        checkOutput({tag, " done"},  32'(done),  32'd0);
    endtask

    // Check the DONE cycle.
    task automatic checkDone(input string tag, input logic [7:0] spn,
                             input logic wr);
        checkOutput({tag, " done"},    32'(done),    32'd1);
        checkOutput({tag, " sp_load"}, 32'(sp_load), 32'd1);
        checkOutput({tag, " sp_next"}, 32'(sp_next), 32'(spn));
        checkOutput({tag, " wr_en"},   32'(wr_en),   32'd0);
        checkOutput({tag, " busy"},    32'(busy),    32'd1);
        checkOutput({tag, " wrap"},    32'(wrap),    32'(wr));
    endtask

    // Check the first IDLE cycle after a frame.
    task automatic checkIdle(input string tag);
        checkOutput({tag, " busy"},    32'(busy),    32'd0);
        checkOutput({tag, " done"},    32'(done),    32'd0);
        checkOutput({tag, " sp_load"}, 32'(sp_load), 32'd0);
        checkOutput({tag, " wr_en"},   32'(wr_en),   32'd0);
    endtask

    initial begin
        reset = 1'b1;
        applyStimulus(1'b0, 2'd0, 8'h00, 16'h0000, 8'h00, 1'b0, 8'h00);
        step();
        step();

        // Reset state
        checkOutput("rst busy",    32'(busy),     32'd0);
        checkOutput("rst wr_en",   32'(wr_en),    32'd0);
        checkOutput("rst addr",    32'(addr),     32'd0);
        checkOutput("rst data",    32'(data_out), 32'd0);
        checkOutput("rst done",    32'(done),     32'd0);
        checkOutput("rst sp_load", 32'(sp_load),  32'd0);
        checkOutput("rst sp_next", 32'(sp_next),  32'd0);
        checkOutput("rst err",     32'(err),      32'd0);
        checkOutput("rst wrap",    32'(wrap),     32'd0);
        reset = 1'b0;
        step();

        // Kind 0, sp=FF, data A5
        applyStimulus(1'b1, 2'd0, 8'hA5, 16'h0000, 8'h00, 1'b0, 8'hFF);
        step();
        applyStimulus(1'b0, 2'd0, 8'h00, 16'h0000, 8'h00, 1'b0, 8'h00);
        checkWrite("k0 w0", 16'h01FF, 8'hA5);
        step();
        checkDone("k0 done", 8'hFE, 1'b0);
        checkOutput("k0 addr hold", 32'(addr), 32'h01FF);
        step();
        checkIdle("k0 idle");

        // Kind 1, sp=FD, pc=C123, push_req pulsed during PUSH1
        applyStimulus(1'b1, 2'd1, 8'h00, 16'hC123, 8'h00, 1'b0, 8'hFD);
        step();
        applyStimulus(1'b0, 2'd0, 8'h00, 16'h0000, 8'h00, 1'b0, 8'h00);
        checkWrite("k1 w0", 16'h01FD, 8'hC1);
        step();
        checkWrite("k1 w1", 16'h01FC, 8'h23);
        applyStimulus(1'b1, 2'd0, 8'h77, 16'h0000, 8'h00, 1'b0, 8'h40);
        step();
        applyStimulus(1'b0, 2'd0, 8'h00, 16'h0000, 8'h00, 1'b0, 8'h00);
        checkDone("k1 done", 8'hFB, 1'b0);
        step();
        checkIdle("k1 idle");
        step();
        checkIdle("k1 no restart");

        // Kind 2, brk=1, sp=FF, pc=8004, status=C3
        applyStimulus(1'b1, 2'd2, 8'h00, 16'h8004, 8'hC3, 1'b1, 8'hFF);
        step();
        applyStimulus(1'b0, 2'd0, 8'h00, 16'h0000, 8'h00, 1'b0, 8'h00);
        checkWrite("k2a w0", 16'h01FF, 8'h80);
        step();
        checkWrite("k2a w1", 16'h01FE, 8'h04);
        step();
        checkWrite("k2a w2", 16'h01FD, 8'hF3);
        step();
        checkDone("k2a done", 8'hFC, 1'b0);
        step();
        checkIdle("k2a idle");

        // Kind 2, brk=0, sp=01, status=00: passes slot 00
`ifdef STACK_WRAP_FLAG_EN
        exp_wrap = 1'b1;
`else
        exp_wrap = 1'b0;
`endif
        applyStimulus(1'b1, 2'd2, 8'h00, 16'h1234, 8'h00, 1'b0, 8'h01);
        step();
        applyStimulus(1'b0, 2'd0, 8'h00, 16'h0000, 8'h00, 1'b0, 8'h00);
        checkWrite("k2b w0", 16'h0101, 8'h12);
        step();
        checkWrite("k2b w1", 16'h0100, 8'h34);
        step();
        checkWrite("k2b w2", 16'h01FF, 8'h20);
        step();
        checkDone("k2b done", 8'hFE, exp_wrap);
        step();
        checkIdle("k2b idle");
        checkOutput("k2b wrap low", 32'(wrap), 32'd0);

        // Kind 2 abandoned by reset in PUSH1
        applyStimulus(1'b1, 2'd2, 8'h00, 16'hABCD, 8'h00, 1'b0, 8'hF0);
        step();
        applyStimulus(1'b0, 2'd0, 8'h00, 16'h0000, 8'h00, 1'b0, 8'h00);
        checkWrite("rstmid w0", 16'h01F0, 8'hAB);
        step();
        checkWrite("rstmid w1", 16'h01EF, 8'hCD);
        reset = 1'b1;
        step();
        reset = 1'b0;
        checkOutput("rstmid wr_en",   32'(wr_en),   32'd0);
        checkOutput("rstmid busy",    32'(busy),    32'd0);
        checkOutput("rstmid sp_next", 32'(sp_next), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            checkIdle("rstmid after");
        end

        // Kind 0 after the abandoned frame
        applyStimulus(1'b1, 2'd0, 8'h5A, 16'h0000, 8'h00, 1'b0, 8'h80);
        step();
        applyStimulus(1'b0, 2'd0, 8'h00, 16'h0000, 8'h00, 1'b0, 8'h00);
        checkWrite("post w0", 16'h0180, 8'h5A);
        step();
        checkDone("post done", 8'h7F, 1'b0);
        step();
        checkIdle("post idle");

        // Reserved kind
        applyStimulus(1'b1, 2'd3, 8'h11, 16'h2222, 8'h33, 1'b0, 8'h44);
        step();
        applyStimulus(1'b0, 2'd0, 8'h00, 16'h0000, 8'h00, 1'b0, 8'h00);
        checkOutput("k3 err",     32'(err),     32'd1);
        checkIdle("k3");
        step();
        checkOutput("k3 err off", 32'(err),     32'd0);
        checkIdle("k3 after");

        // Held push_req: re-accepted in the first IDLE cycle
        applyStimulus(1'b1, 2'd0, 8'h3C, 16'h0000, 8'h00, 1'b0, 8'h10);
        step();
        checkWrite("held w0", 16'h0110, 8'h3C);
        step();
        checkDone("held done", 8'h0F, 1'b0);
        step();
        checkIdle("held idle");
        step();
        applyStimulus(1'b0, 2'd0, 8'h00, 16'h0000, 8'h00, 1'b0, 8'h00);
        checkWrite("held w0 again", 16'h0110, 8'h3C);
        step();
        checkDone("held done again", 8'h0F, 1'b0);
        step();
        checkIdle("held idle again");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
